// File: rtl/decode_issue_16bit_pkg.sv
// -----------------------------------------------------------------------------
// decode_issue_16bit_pkg
//
// Shared definitions for the decode/issue stage and its neighbours (ALU and
// writeback). Holds the instruction-word layout, the NOP opcode, default
// datapath widths and the architectural register-index width, plus a helper
// that splits a raw instruction word into its fields.
//
// Instruction word layout (16 bits):
//   [15:10] opcode   [9:7] rd   [6:4] rs1   [3:1] rs2 / imm3   [0] imm_sel
// -----------------------------------------------------------------------------
package decode_issue_16bit_pkg;

    // Default widths of the datapath and the ALU opcode bus.
    localparam int DATA_W_DEFAULT = 16;
    localparam int OP_W_DEFAULT   = 6;
    localparam int NREGS_DEFAULT  = 8;

    // Instruction word geometry.
    localparam int INSTR_W     = 16;
    localparam int OPC_W       = 6;
    localparam int REG_IDX_W   = 3;
    localparam int IMM_W       = 3;
    localparam int OPC_LSB     = 10;
    localparam int RD_LSB      = 7;
    localparam int RS1_LSB     = 4;
    localparam int RS2_LSB     = 1;
    localparam int IMM_SEL_BIT = 0;

    // Opcode 0 is a NOP: it issues like any instruction but reserves nothing.
    localparam logic [OPC_W-1:0] OP_NOP = '0;

    typedef struct packed {
        logic [OPC_W-1:0]     opcode;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;      // doubles as the 3-bit immediate
        logic                 imm_sel;
    } instr_fields_t;

    // Split a raw instruction word into named fields.
    function automatic instr_fields_t decode_instr(input logic [INSTR_W-1:0] word);
        instr_fields_t fields;
        fields.opcode  = word[OPC_LSB +: OPC_W];
        fields.rd      = word[RD_LSB +: REG_IDX_W];
        fields.rs1     = word[RS1_LSB +: REG_IDX_W];
        fields.rs2     = word[RS2_LSB +: REG_IDX_W];
        fields.imm_sel = word[IMM_SEL_BIT];
        return fields;
    endfunction

endpackage

// File: rtl/decode_issue_16bit_regfile.sv
// -----------------------------------------------------------------------------
// regfile_16x8
//
// Architectural register file: NREGS x DATA_W, two combinational read ports
// and one write port, with write-to-read bypass. r0 is hard-wired to zero and
// never stored, so writes to it vanish and it can never be bypassed.
//
// The storage is built from flops rather than a RAM: the whole file must clear
// on reset and the read ports must see this cycle's writeback data, neither of
// which a registered-read RAM can provide.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high clear
//   ra1, ra2      read addresses
//   rd1, rd2      read data (bypassed from wd when we && wa == raN != 0)
//   we, wa, wd    write enable / address / data from writeback
// -----------------------------------------------------------------------------
module regfile_16x8
    import decode_issue_16bit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [DATA_W-1:0]    rd1,
    output logic [DATA_W-1:0]    rd2,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd
);

    // Current contents of every register, with entry 0 tied to zero.
    logic [DATA_W-1:0] rf_q [NREGS];

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : gen_reg
            if (gi == 0) begin : gen_zero
                assign rf_q[gi] = '0;
            end else begin : gen_cell
                logic [DATA_W-1:0] cell_reg;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cell_reg <= '0;
                    end else if (we && (wa == REG_IDX_W'(gi))) begin
                        cell_reg <= wd;
                    end
                end

                assign rf_q[gi] = cell_reg;
            end
        end
    endgenerate

    // Bypass: a read of the register being written this cycle returns the
    // incoming data so an issuing instruction never sees a stale value.
    // Address 0 is excluded so r0 keeps reading as zero.
    always_comb begin
        rd1 = rf_q[ra1];
        if (we && (wa == ra1) && (ra1 != '0)) begin
            rd1 = wd;
        end
    end

    always_comb begin
        rd2 = rf_q[ra2];
        if (we && (wa == ra2) && (ra2 != '0)) begin
            rd2 = wd;
        end
    end

endmodule

// File: rtl/decode_issue_16bit.sv
// -----------------------------------------------------------------------------
// decode_issue_16bit
//
// Decode and issue stage. Decodes a 16-bit instruction, reads its source
// operands from the register file (with writeback bypass), checks a busy
// scoreboard for read-after-write hazards and, when the output register is
// free or being drained, issues the instruction into registered ALU operands.
//
// Ports:
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   instr, in_valid, in_ready  instruction input handshake
//   A, B, op_dec, rd_ex        registered ALU operands, opcode, destination
//   out_valid, out_ready       output handshake (op_dec reads 0 when empty)
//   wb_en, wb_addr, wb_data    register-file write from writeback; also
//                              releases the destination's busy bit
// -----------------------------------------------------------------------------
module decode_issue_16bit
    import decode_issue_16bit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int OP_W   = OP_W_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATA_W-1:0]    A,
    output logic [DATA_W-1:0]    B,
    output logic [OP_W-1:0]      op_dec,
    output logic [REG_IDX_W-1:0] rd_ex,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]    wb_data
);

    // ---------------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------------
    instr_fields_t fields;
    assign fields = decode_instr(instr);

    logic [DATA_W-1:0] rs1_val;
    logic [DATA_W-1:0] rs2_val;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_next;

    regfile_16x8 #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (fields.rs1),
        .ra2   (fields.rs2),
        .rd1   (rs1_val),
        .rd2   (rs2_val),
        .we    (wb_en),
        .wa    (wb_addr),
        .wd    (wb_data)
    );

    // The rs2 field carries a signed 3-bit immediate (-4..3) when imm_sel=1.
    assign imm_ext = {{(DATA_W-IMM_W){fields.rs2[IMM_W-1]}}, fields.rs2};
    assign b_next  = fields.imm_sel ? imm_ext : rs2_val;

    // ---------------------------------------------------------------------
    // Hazard detection and issue handshake
    // ---------------------------------------------------------------------
    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic             rs1_wb_now;
    logic             rs2_wb_now;
    logic             hazard;
    logic             issue;
    logic             out_valid_reg;

    // A source whose producer is writing back this very cycle is not a
    // hazard: the bypass already delivers the value.
    assign rs1_wb_now = wb_en && (wb_addr == fields.rs1);
    assign rs2_wb_now = wb_en && (wb_addr == fields.rs2);

    // rs2 only matters when B comes from the register file.
    assign hazard = (busy_reg[fields.rs1] && !rs1_wb_now)
                 || (!fields.imm_sel && busy_reg[fields.rs2] && !rs2_wb_now);

    assign in_ready = !reset && (!out_valid_reg || out_ready) && !hazard;
    assign issue    = in_valid && in_ready;

    // ---------------------------------------------------------------------
    // Busy scoreboard: one bit per register, bit 0 constant zero.
    // Setting on issue takes precedence over a same-cycle writeback clear,
    // because the new producer is younger than the one retiring.
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : gen_busy
            if (gi == 0) begin : gen_r0
                assign busy_next[gi] = 1'b0;
            end else begin : gen_rn
                logic set_bit;
                logic clr_bit;

                assign set_bit = issue && (fields.opcode != OP_NOP)
                              && (fields.rd == REG_IDX_W'(gi));
                assign clr_bit = wb_en && (wb_addr == REG_IDX_W'(gi));

                assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // ---------------------------------------------------------------------
    // Output register
    // A consume without a new issue empties the stage and forces op_dec to
    // the NOP code, so the ALU sees bubbles as NOPs. A, B and rd_ex keep
    // their last values then; they are only meaningful with out_valid.
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0]    a_reg;
    logic [DATA_W-1:0]    b_reg;
    logic [OP_W-1:0]      op_reg;
    logic [REG_IDX_W-1:0] rd_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            rd_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else if (issue) begin
            a_reg         <= rs1_val;
            b_reg         <= b_next;
            op_reg        <= OP_W'(fields.opcode);
            rd_reg        <= fields.rd;
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            op_reg        <= '0;
            out_valid_reg <= 1'b0;
        end
    end

    assign A         = a_reg;
    assign B         = b_reg;
    assign op_dec    = op_reg;
    assign rd_ex     = rd_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_decode_issue_16bit.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_16bit
//
// Directed scenarios with literal expectations, followed by a short stretch of
// pseudo-random traffic. A behavioural model of the stage (register array,
// busy flags and the output slot) runs alongside and is compared against the
// DUT every cycle: in_ready before each rising edge, the outputs after it.
// -----------------------------------------------------------------------------
module tb_decode_issue_16bit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [5:0]  op_dec;
    logic [2:0]  rd_ex;
    logic        out_valid;
    logic        out_ready;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    always #5 clk = ~clk;

    decode_issue_16bit dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op_dec    (op_dec),
        .rd_ex     (rd_ex),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [15:0] m_rf [8];
    bit          m_busy [8];
    bit          m_valid;
    logic [15:0] m_a;
    logic [15:0] m_b;
    int          m_op;
    int          m_rd;

    function automatic logic [15:0] m_read(input int idx);
        if (idx == 0) return 16'h0000;
        if (wb_en && int'(wb_addr) == idx) return wb_data;
        return m_rf[idx];
    endfunction

    int          c_opc, c_rd, c_rs1, c_rs2, c_imm, c_sx;
    bit          c_haz, c_ready, c_issue;
    logic [15:0] c_a, c_b;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            c_opc = (int'(instr) >> 10) & 63;
            c_rd  = (int'(instr) >> 7) & 7;
            c_rs1 = (int'(instr) >> 4) & 7;
            c_rs2 = (int'(instr) >> 1) & 7;
            c_imm = int'(instr) & 1;
            c_haz = (m_busy[c_rs1] && !(wb_en && int'(wb_addr) == c_rs1))
                 || (c_imm == 0 && m_busy[c_rs2] && !(wb_en && int'(wb_addr) == c_rs2));
            c_ready = !reset && (!m_valid || out_ready) && !c_haz;
            c_issue = in_valid && c_ready;
            c_a = m_read(c_rs1);
            if (c_imm == 1) begin
                c_sx = c_rs2;
                if (c_sx > 3) c_sx = c_sx - 8;
                c_b = 16'(c_sx);
            end else begin
                c_b = m_read(c_rs2);
            end
            check("model_in_ready", {31'b0, in_ready}, {31'b0, c_ready});

            @(posedge clk);
            #1;
            if (reset) begin
                for (int i = 0; i < 8; i++) begin
                    m_rf[i]   = 16'h0000;
                    m_busy[i] = 1'b0;
                end
                m_valid = 1'b0;
                m_a = 16'h0000;
                m_b = 16'h0000;
                m_op = 0;
                m_rd = 0;
            end else begin
                if (c_issue) begin
                    m_a = c_a;
                    m_b = c_b;
                    m_op = c_opc;
                    m_rd = c_rd;
                    m_valid = 1'b1;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                    m_op = 0;
                end
                if (wb_en) begin
                    if (wb_addr != 3'd0) m_rf[wb_addr] = wb_data;
                    m_busy[wb_addr] = 1'b0;
                end
                if (c_issue && c_opc != 0 && c_rd != 0) m_busy[c_rd] = 1'b1;
            end
            check("model_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
            check("model_op_dec", {26'b0, op_dec}, 32'(m_op));
            if (m_valid) begin
                check("model_A", {16'b0, A}, {16'b0, m_a});
                check("model_B", {16'b0, B}, {16'b0, m_b});
                check("model_rd_ex", {29'b0, rd_ex}, 32'(m_rd));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick(input logic rst, input logic [15:0] ins, input logic iv,
                        input logic ordy, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd);
        @(negedge clk);
        reset     = rst;
        instr     = ins;
        in_valid  = iv;
        out_ready = ordy;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        $display("tick rst=%0b instr=%04h iv=%0b ordy=%0b wb=%0b/%0d/%04h", rst, ins, iv, ordy, we, wa, wd);
    endtask

    initial begin
        reset = 1'b1; instr = '0; in_valid = 1'b0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        tick(1, 16'h0000, 0, 0, 0, 0, 16'h0);
        tick(1, 16'h0000, 0, 0, 0, 0, 16'h0);
        tick(0, 16'h0000, 0, 1, 0, 0, 16'h0);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_op_dec", {26'b0, op_dec}, 32'd0);
        check("rst_A", {16'b0, A}, 32'd0);
        check("rst_B", {16'b0, B}, 32'd0);
        check("rst_rd_ex", {29'b0, rd_ex}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // op 2, rd1, rs1=r0, imm 3
        tick(0, 16'h0887, 1, 1, 0, 0, 16'h0);
        #1 check("i0887_ready", {31'b0, in_ready}, 32'd1);
        // op 28, rd2, rs1=rs2=r1: blocked on r1
        tick(0, 16'h7112, 1, 1, 0, 0, 16'h0);
        #1;
        check("i0887_A", {16'b0, A}, 32'h0000);
        check("i0887_B", {16'b0, B}, 32'h0003);
        check("i0887_op", {26'b0, op_dec}, 32'd2);
        check("i0887_rd", {29'b0, rd_ex}, 32'd1);
        check("i0887_valid", {31'b0, out_valid}, 32'd1);
        check("raw_r1_blocked", {31'b0, in_ready}, 32'd0);
        tick(0, 16'h7112, 1, 1, 0, 0, 16'h0);
        #1;
        check("raw_r1_blocked2", {31'b0, in_ready}, 32'd0);
        check("bubble_valid", {31'b0, out_valid}, 32'd0);
        check("bubble_op_nop", {26'b0, op_dec}, 32'd0);
        // writeback r1=5 releases the hazard in the same cycle
        tick(0, 16'h7112, 1, 1, 1, 3'd1, 16'h0005);
        #1 check("wb_bypass_ready", {31'b0, in_ready}, 32'd1);
        // op 3, rd3, rs1=r1, imm -4
        tick(0, 16'h0D99, 1, 1, 0, 0, 16'h0);
        #1;
        check("i7112_A", {16'b0, A}, 32'h0005);
        check("i7112_B", {16'b0, B}, 32'h0005);
        check("i7112_op", {26'b0, op_dec}, 32'd28);
        check("i7112_rd", {29'b0, rd_ex}, 32'd2);
        check("i0D99_ready", {31'b0, in_ready}, 32'd1);
        // stall three cycles with op 4, rd4, rs1=r1, imm 1 waiting
        tick(0, 16'h1213, 1, 0, 0, 0, 16'h0);
        #1;
        check("imm_neg4_B", {16'b0, B}, 32'hFFFC);
        check("i0D99_A", {16'b0, A}, 32'h0005);
        check("i0D99_op", {26'b0, op_dec}, 32'd3);
        check("stall_ready", {31'b0, in_ready}, 32'd0);
        repeat (2) begin
            tick(0, 16'h1213, 1, 0, 0, 0, 16'h0);
            #1;
            check("stall_hold_B", {16'b0, B}, 32'hFFFC);
            check("stall_hold_op", {26'b0, op_dec}, 32'd3);
            check("stall_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        tick(0, 16'h1213, 1, 1, 0, 0, 16'h0);
        #1;
        check("stall_end_valid", {31'b0, out_valid}, 32'd1);
        check("stall_end_op", {26'b0, op_dec}, 32'd3);
        check("b2b_ready", {31'b0, in_ready}, 32'd1);
        // op 7 rd4 issues while writeback clears r4: set must win
        tick(0, 16'h1E01, 1, 1, 1, 3'd4, 16'h0009);
        #1;
        check("b2b_op", {26'b0, op_dec}, 32'd4);
        check("b2b_A", {16'b0, A}, 32'h0005);
        check("b2b_B", {16'b0, B}, 32'h0001);
        check("b2b_rd", {29'b0, rd_ex}, 32'd4);
        check("b2b_valid", {31'b0, out_valid}, 32'd1);
        // rs1=r4 must still be blocked
        tick(0, 16'h20C1, 1, 1, 0, 0, 16'h0);
        #1;
        check("set_wins_op", {26'b0, op_dec}, 32'd7);
        check("set_wins_blocked", {31'b0, in_ready}, 32'd0);
        // write to r0 while reading it, then read it again
        tick(0, 16'h1681, 1, 1, 1, 3'd0, 16'hFFFF);
        #1 check("r0_wr_ready", {31'b0, in_ready}, 32'd1);
        tick(0, 16'h1681, 1, 1, 0, 0, 16'h0);
        #1;
        check("r0_same_cycle_A", {16'b0, A}, 32'h0000);
        check("r0_op", {26'b0, op_dec}, 32'd5);
        tick(0, 16'h1B36, 0, 1, 0, 0, 16'h0);
        #1;
        check("r0_after_A", {16'b0, A}, 32'h0000);
        check("r3_busy_blocked", {31'b0, in_ready}, 32'd0);
        // reset mid-operation with a competing writeback
        tick(1, 16'h1B36, 1, 1, 1, 3'd2, 16'h1234);
        #1 check("reset_ready", {31'b0, in_ready}, 32'd0);
        tick(0, 16'h1B36, 0, 1, 0, 0, 16'h0);
        #1;
        check("post_rst_valid", {31'b0, out_valid}, 32'd0);
        check("post_rst_op", {26'b0, op_dec}, 32'd0);
        check("post_rst_busy3_clear", {31'b0, in_ready}, 32'd1);
        tick(0, 16'h1B36, 1, 1, 0, 0, 16'h0);
        tick(0, 16'h0000, 0, 1, 0, 0, 16'h0);
        #1;
        check("post_rst_A", {16'b0, A}, 32'h0000);
        check("post_rst_B", {16'b0, B}, 32'h0000);
        check("post_rst_op6", {26'b0, op_dec}, 32'd6);
        check("post_rst_rd", {29'b0, rd_ex}, 32'd6);

        // pseudo-random traffic, checked by the model only
        for (int i = 0; i < 80; i++) begin
            tick(0, 16'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 16'($urandom));
        end
        tick(0, 16'h0000, 0, 1, 0, 0, 16'h0);
        tick(0, 16'h0000, 0, 1, 0, 0, 16'h0);
        @(negedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_issue_16bit.md
DECODE_ISSUE_16BIT -- requirements
Module: decode_issue_16bit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width of A, B and register contents.
REQ-002 SHALL have parameter OP_W, default 6, opcode width; matches op_dec of the downstream ALU.
REQ-003 SHALL have parameter NREGS, default 8, number of architectural registers; index width 3.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port instr  input  16  instruction word: [15:10] opcode, [9:7] rd, [6:4] rs1, [3:1] rs2, [0] imm_sel.
REQ-007 SHALL have port in_valid  input  1  instr is valid this cycle.
REQ-008 SHALL have port in_ready  output  1  block accepts instr this cycle.
REQ-009 SHALL have port A  output  DATA_W  registered operand 1 to the ALU.
REQ-010 SHALL have port B  output  DATA_W  registered operand 2 to the ALU.
REQ-011 SHALL have port op_dec  output  OP_W  registered opcode to the ALU.
REQ-012 SHALL have port rd_ex  output  3  registered destination index, carried to writeback.
REQ-013 SHALL have port out_valid  output  1  A/B/op_dec/rd_ex hold an issued instruction.
REQ-014 SHALL have port out_ready  input  1  downstream consumes the output this cycle.
REQ-015 SHALL have ports wb_en  input  1, wb_addr  input  3, wb_data  input  DATA_W: register-file write from writeback.

Function
REQ-016 SHALL hold an NREGS x DATA_W register file; r0 SHALL read as 0, and writes to r0 SHALL be ignored.
REQ-017 SHALL write wb_data to wb_addr on a clock edge with wb_en=1 and wb_addr!=0.
REQ-018 SHALL bypass reads: a read of rsN with wb_en=1 and wb_addr==rsN!=0 in the same cycle SHALL return wb_data.
REQ-019 SHALL keep an NREGS-bit busy scoreboard; busy[0] SHALL always read 0.
REQ-020 SHALL flag a hazard when busy[rs1]=1 and rs1 is not being written back this cycle, or likewise for rs2 with imm_sel=0.
REQ-021 SHALL drive in_ready = (!out_valid || out_ready) && !hazard; issue occurs when in_valid && in_ready.
REQ-022 SHALL, on issue, register A=RF[rs1] (bypassed), op_dec=opcode, rd_ex=rd, out_valid=1, with 1-cycle latency.
REQ-023 SHALL set B=RF[rs2] (bypassed) when imm_sel=0, and B=sign-extend(instr[3:1]) (range -4..3) when imm_sel=1.
REQ-024 SHALL set busy[rd] on issue when opcode!=0 and rd!=0; opcode 0 is NOP and reserves nothing.
REQ-025 SHALL clear busy[wb_addr] on wb_en; if an issue sets the same index in the same cycle, set SHALL win.
REQ-026 SHALL clear out_valid when out_ready=1 and no issue occurs; an issue and a consume in the same cycle SHALL leave out_valid=1 with the new contents.
REQ-027 SHALL hold A, B, op_dec and rd_ex stable while out_valid=1 and out_ready=0.
REQ-028 SHALL drive op_dec=0 whenever out_valid=0, so that the ALU sees a bubble as NOP.

Reset
REQ-029 SHALL, on reset=1 at a clock edge, clear the register file, busy, out_valid, A, B, op_dec and rd_ex to 0.
REQ-030 SHALL give reset priority over a simultaneous issue or writeback; in_ready SHALL be 0 while reset=1.
REQ-031 SHALL discard any instruction in flight at reset mid-operation; no stale busy bits SHALL survive.

Structure
REQ-032 SHALL place the instruction field positions, the NOP opcode (0), DATA_W/OP_W defaults and the register-index width in a shared package, for use by the ALU and writeback stages.
REQ-033 SHALL implement the register file with its bypass as one sub-module, regfile_16x8, with 2 read ports and 1 write port; the scoreboard and output register live in the top level.

Verification
REQ-034 SHALL cover: after reset, instr=0x0887 (op 2, rd1, rs1=r0, imm 3), out_ready=1 -> next cycle A=0, B=0x0003, op_dec=2, rd_ex=1, out_valid=1, busy[1]=1.
REQ-035 SHALL cover: then instr=0x7112 (op 28, rd2, rs1=rs2=r1) -> in_ready=0 until wb_en=1, wb_addr=1, wb_data=5; issue occurs that same cycle -> A=5, B=5, op_dec=28.
REQ-036 SHALL cover: an imm_sel=1 instruction with instr[3:1]=3'b100 -> B=0xFFFC.
REQ-037 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> outputs unchanged and in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back issue, out_valid stays 1.
REQ-038 SHALL cover: a write to r0 (wb_addr=0, wb_data=0xFFFF) followed by a read of r0 -> A=0; reset asserted while busy[3]=1 -> busy=0, out_valid=0, op_dec=0 next cycle.
